// File: rtl/sopc_mmio_bridge_pkg.sv
// Shared IO-window offsets, CTRL bit positions and timer write strobes for the
// SoPC MMIO bridge.
package sopc_mmio_bridge_pkg;

  localparam logic [7:0] SOPC_IO_LED     = 8'h00;
  localparam logic [7:0] SOPC_IO_SW      = 8'h04;
  localparam logic [7:0] SOPC_IO_COUNT   = 8'h08;
  localparam logic [7:0] SOPC_IO_COMPARE = 8'h0C;
  localparam logic [7:0] SOPC_IO_CTRL    = 8'h10;
  localparam logic [7:0] SOPC_IO_STATUS  = 8'h14;

  localparam int SOPC_CTRL_EN = 0;
  localparam int SOPC_CTRL_IE = 1;

  typedef struct packed {
    logic count_we;
    logic compare_we;
    logic ctrl_we;
    logic status_we;
  } timer_wr_t;

  function automatic logic in_io_window(input logic [31:0] addr, input logic [31:0] base);
    return addr[31:8] == base[31:8];
  endfunction

  // Only word accesses exist, so the byte lane bits never take part in decode.
  function automatic logic [7:0] word_offset(input logic [5:0] word_idx);
    return {word_idx, 2'b00};
  endfunction

endpackage

// File: rtl/sopc_timer.sv
// Compare timer: free-running count with wrap at COMPARE, sticky match flag
// (write-1-to-clear) and a level interrupt gated by the CTRL ie bit.
module sopc_timer
  import sopc_mmio_bridge_pkg::*;
#(
  parameter int TIMER_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  timer_wr_t          wr,
  input  logic [TIMER_W-1:0] wdata,
  output logic [TIMER_W-1:0] count_o,
  output logic [TIMER_W-1:0] compare_o,
  output logic [1:0]         ctrl_o,
  output logic               irq_pend_o,
  output logic               timer_int_o
);

  logic [TIMER_W-1:0] count_reg;
  logic [TIMER_W-1:0] compare_reg;
  logic [1:0]         ctrl_reg;
  logic               irq_pend_reg;
  logic               match;

  assign match = ctrl_reg[SOPC_CTRL_EN] && (count_reg == compare_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg    <= '0;
      compare_reg  <= '1;
      ctrl_reg     <= '0;
      irq_pend_reg <= 1'b0;
    end else begin
      // A software COUNT write overrides both increment and wrap.
      if (wr.count_we)
        count_reg <= wdata;
      else if (match)
        count_reg <= '0;
      else if (ctrl_reg[SOPC_CTRL_EN])
        count_reg <= count_reg + 1'b1;

      if (wr.compare_we)
        compare_reg <= wdata;
      if (wr.ctrl_we)
        ctrl_reg <= wdata[1:0];

      // A new match wins over a simultaneous clear so no event is lost.
      if (match)
        irq_pend_reg <= 1'b1;
      else if (wr.status_we && wdata[0])
        irq_pend_reg <= 1'b0;
    end
  end

  assign count_o     = count_reg;
  assign compare_o   = compare_reg;
  assign ctrl_o      = ctrl_reg;
  assign irq_pend_o  = irq_pend_reg;
  assign timer_int_o = irq_pend_reg & ctrl_reg[SOPC_CTRL_IE];

endmodule

// File: rtl/sopc_mmio_bridge.sv
// Core data-port bridge: splits accesses between data_ram and an IO window holding
// LEDs, switches and a compare timer. Define SOPC_SW_DEBOUNCE_EN to debounce switches.
module sopc_mmio_bridge
  import sopc_mmio_bridge_pkg::*;
#(
  parameter logic [31:0] IO_BASE    = 32'h1000_0000,
  parameter int          LED_W      = 16,
  parameter int          SW_W       = 12,
  parameter int          TIMER_W    = 32,
  parameter int          DEB_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_ce_i,
  input  logic              core_we_i,
  input  logic [31:0]       core_addr_i,
  input  logic [31:0]       core_data_i,
  output logic [31:0]       core_data_o,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [31:0]       ram_addr_o,
  output logic [31:0]       ram_data_o,
  input  logic [31:0]       ram_data_i,
  input  logic [SW_W-1:0]   switch_i,
  output logic [LED_W-1:0]  led_o,
  output logic              timer_int_o
);

  logic               io_sel;
  logic               io_wr;
  logic [7:0]         io_off;
  logic [31:0]        io_rdata;
  logic               unused_addr_lsbs;
  logic [LED_W-1:0]   led_reg;
  logic [SW_W-1:0]    sw_meta_reg;
  logic [SW_W-1:0]    sw_sync_reg;
  logic [SW_W-1:0]    sw_value;
  timer_wr_t          timer_wr;
  logic [TIMER_W-1:0] timer_count;
  logic [TIMER_W-1:0] timer_compare;
  logic [1:0]         timer_ctrl;
  logic               timer_irq_pend;

  assign io_sel           = in_io_window(core_addr_i, IO_BASE);
  assign io_off           = word_offset(core_addr_i[7:2]);
  assign io_wr            = core_ce_i & core_we_i & io_sel;
  assign unused_addr_lsbs = ^core_addr_i[1:0];

  assign ram_ce_o   = core_ce_i & ~io_sel;
  assign ram_we_o   = core_we_i;
  assign ram_addr_o = core_addr_i;
  assign ram_data_o = core_data_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      led_reg <= '0;
    else if (io_wr && io_off == SOPC_IO_LED)
      led_reg <= core_data_i[LED_W-1:0];
  end
  assign led_o = led_reg;

  // Per-bit two-flop synchroniser; switches are independent asynchronous inputs.
  for (genvar gi = 0; gi < SW_W; gi++) begin : g_sw_sync
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sw_meta_reg[gi] <= 1'b0;
        sw_sync_reg[gi] <= 1'b0;
      end else begin
        sw_meta_reg[gi] <= switch_i[gi];
        sw_sync_reg[gi] <= sw_meta_reg[gi];
      end
    end
  end

`ifdef SOPC_SW_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  logic [SW_W-1:0]  sw_last_reg;
  logic [SW_W-1:0]  sw_stable_reg;
  logic [DEB_W-1:0] deb_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_last_reg   <= '0;
      sw_stable_reg <= '0;
      deb_cnt_reg   <= '0;
    end else if (sw_sync_reg != sw_last_reg) begin
      sw_last_reg <= sw_sync_reg;
      deb_cnt_reg <= '0;
    end else if (deb_cnt_reg == DEB_W'(DEB_CYCLES - 1)) begin
      sw_stable_reg <= sw_last_reg;
    end else begin
      deb_cnt_reg <= deb_cnt_reg + 1'b1;
    end
  end
  assign sw_value = sw_stable_reg;
`else
  assign sw_value = sw_sync_reg;
`endif

  always_comb begin
    timer_wr            = '0;
    timer_wr.count_we   = io_wr && (io_off == SOPC_IO_COUNT);
    timer_wr.compare_we = io_wr && (io_off == SOPC_IO_COMPARE);
    timer_wr.ctrl_we    = io_wr && (io_off == SOPC_IO_CTRL);
    timer_wr.status_we  = io_wr && (io_off == SOPC_IO_STATUS);
  end

  sopc_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .wr          (timer_wr),
    .wdata       (core_data_i[TIMER_W-1:0]),
    .count_o     (timer_count),
    .compare_o   (timer_compare),
    .ctrl_o      (timer_ctrl),
    .irq_pend_o  (timer_irq_pend),
    .timer_int_o (timer_int_o)
  );

  always_comb begin
    io_rdata = '0;
    case (io_off)
      SOPC_IO_LED:     io_rdata = 32'(led_reg);
      SOPC_IO_SW:      io_rdata = 32'(sw_value);
      SOPC_IO_COUNT:   io_rdata = 32'(timer_count);
      SOPC_IO_COMPARE: io_rdata = 32'(timer_compare);
      SOPC_IO_CTRL:    io_rdata = 32'(timer_ctrl);
      SOPC_IO_STATUS:  io_rdata = 32'(timer_irq_pend);
      default:         io_rdata = '0;
    endcase
  end

  always_comb begin
    core_data_o = '0;
    if (core_ce_i)
      core_data_o = io_sel ? io_rdata : ram_data_i;
  end

endmodule

// File: tb/tb_sopc_mmio_bridge.sv
// Directed bench for sopc_mmio_bridge: decode/read-mux vector table, then hand-written
// timer, W1C, reset and switch-path sequences.
module tb_sopc_mmio_bridge;

  localparam int LED_W = 16;
  localparam int SW_W  = 12;
  localparam int DEB   = 8;

  localparam logic [31:0] A_LED  = 32'h1000_0000;
  localparam logic [31:0] A_SW   = 32'h1000_0004;
  localparam logic [31:0] A_CNT  = 32'h1000_0008;
  localparam logic [31:0] A_CMP  = 32'h1000_000C;
  localparam logic [31:0] A_CTRL = 32'h1000_0010;
  localparam logic [31:0] A_STAT = 32'h1000_0014;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             core_ce_i = 1'b0;
  logic             core_we_i = 1'b0;
  logic [31:0]      core_addr_i = '0;
  logic [31:0]      core_data_i = '0;
  logic [31:0]      core_data_o;
  logic             ram_ce_o;
  logic             ram_we_o;
  logic [31:0]      ram_addr_o;
  logic [31:0]      ram_data_o;
  logic [31:0]      ram_data_i = '0;
  logic [SW_W-1:0]  switch_i = '0;
  logic [LED_W-1:0] led_o;
  logic             timer_int_o;

  int n_vec = 0;
  int n_bad = 0;

  sopc_mmio_bridge #(
    .IO_BASE    (32'h1000_0000),
    .LED_W      (LED_W),
    .SW_W       (SW_W),
    .TIMER_W    (32),
    .DEB_CYCLES (DEB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .core_ce_i   (core_ce_i),
    .core_we_i   (core_we_i),
    .core_addr_i (core_addr_i),
    .core_data_i (core_data_i),
    .core_data_o (core_data_o),
    .ram_ce_o    (ram_ce_o),
    .ram_we_o    (ram_we_o),
    .ram_addr_o  (ram_addr_o),
    .ram_data_o  (ram_data_o),
    .ram_data_i  (ram_data_i),
    .switch_i    (switch_i),
    .led_o       (led_o),
    .timer_int_o (timer_int_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] ram_rd;
    logic [31:0] exp_rd;
    logic        exp_ram_ce;
    logic [15:0] exp_led;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(string name, logic ce, logic we, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] ram_rd, logic [31:0] exp_rd,
                              logic exp_ram_ce, logic [15:0] exp_led);
    vec_t v;
    v.name = name; v.ce = ce; v.we = we; v.addr = addr; v.wdata = wdata;
    v.ram_rd = ram_rd; v.exp_rd = exp_rd; v.exp_ram_ce = exp_ram_ce; v.exp_led = exp_led;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic set_bus(input logic ce, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] ram_rd);
    core_ce_i   = ce;
    core_we_i   = we;
    core_addr_i = addr;
    core_data_i = wdata;
    ram_data_i  = ram_rd;
  endtask

  // Returns 1 ns after the next rising edge, so comparisons stay clear of both edges.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    set_bus(1'b1, 1'b1, addr, data, 32'h0);
    tick();
    set_bus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    int exp_cnt[6];
    logic exp_int[6];

    vecs[0]  = mk("led_wr_a5a5",   1, 1, A_LED,         32'h0000_A5A5, 32'h0,         32'h0,         0, 16'hA5A5);
    vecs[1]  = mk("led_rd",        1, 0, A_LED,         32'h0,         32'h0,         32'h0000_A5A5, 0, 16'hA5A5);
    vecs[2]  = mk("ram_wr_0x40",   1, 1, 32'h0000_0040, 32'h0000_1234, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 16'hA5A5);
    vecs[3]  = mk("unmapped_rd",   1, 0, 32'h1000_0020, 32'h0,         32'h5555_5555, 32'h0,         0, 16'hA5A5);
    vecs[4]  = mk("unmapped_wr",   1, 1, 32'h1000_0020, 32'h0000_FFFF, 32'h0,         32'h0,         0, 16'hA5A5);
    vecs[5]  = mk("count_rst_rd",  1, 0, A_CNT,         32'h0,         32'h0,         32'h0,         0, 16'hA5A5);
    vecs[6]  = mk("compare_rst",   1, 0, A_CMP,         32'h0,         32'h0,         32'hFFFF_FFFF, 0, 16'hA5A5);
    vecs[7]  = mk("led_wr_trunc",  1, 1, A_LED,         32'hFFFF_1234, 32'h0,         32'h0000_A5A5, 0, 16'h1234);
    vecs[8]  = mk("led_rd_trunc",  1, 0, A_LED,         32'h0,         32'h0,         32'h0000_1234, 0, 16'h1234);
    vecs[9]  = mk("ram_rd_far",    1, 0, 32'h2000_1000, 32'h0,         32'h1111_2222, 32'h1111_2222, 1, 16'h1234);
    vecs[10] = mk("ram_rd_edge",   1, 0, 32'h1000_0100, 32'h0,         32'h3333_4444, 32'h3333_4444, 1, 16'h1234);
    vecs[11] = mk("ctrl_rst_rd",   1, 0, A_CTRL,        32'h0,         32'h0,         32'h0,         0, 16'h1234);
    vecs[12] = mk("led_wr_lsb11",  1, 1, 32'h1000_0003, 32'h0000_00FF, 32'h0,         32'h0000_1234, 0, 16'h00FF);
    vecs[13] = mk("ce0_rd",        0, 0, A_LED,         32'h0,         32'hCAFE_F00D, 32'h0,         0, 16'h00FF);
    vecs[14] = mk("ce0_wr",        0, 1, A_LED,         32'h0000_BEEF, 32'h0,         32'h0,         0, 16'h00FF);

    // Reset state, sampled while rst is still asserted.
    set_bus(1'b1, 1'b0, A_CNT, 32'h0, 32'h0);
    #12;
    check("rst_led", 32'(led_o), 32'h0);
    check("rst_int", 32'(timer_int_o), 32'h0);
    check("rst_count", core_data_o, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    foreach (vecs[i]) begin
      set_bus(vecs[i].ce, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].ram_rd);
      #3;
      check({vecs[i].name, "/rdata"}, core_data_o, vecs[i].exp_rd);
      check({vecs[i].name, "/ram_ce"}, 32'(ram_ce_o), 32'(vecs[i].exp_ram_ce));
      tick();
      check({vecs[i].name, "/led"}, 32'(led_o), 32'(vecs[i].exp_led));
    end

    // Timer counts 0..COMPARE then wraps; interrupt follows the wrap edge.
    wr(A_CMP, 32'd4);
    wr(A_CTRL, 32'd3);
    exp_cnt = '{0, 1, 2, 3, 4, 0};
    exp_int = '{0, 0, 0, 0, 0, 1};
    set_bus(1'b1, 1'b0, A_CNT, 32'h0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      #3;
      check($sformatf("wrap_count[%0d]", i), core_data_o, 32'(exp_cnt[i]));
      check($sformatf("wrap_int[%0d]", i), 32'(timer_int_o), 32'(exp_int[i]));
      tick();
    end

    // W1C in the same cycle as a match: the set wins.
    repeat (3) tick();
    #3;
    check("w1c_pre_count", core_data_o, 32'd4);
    set_bus(1'b1, 1'b1, A_STAT, 32'h1, 32'h0);
    tick();
    #3;
    check("w1c_vs_match_int", 32'(timer_int_o), 32'h1);
    check("w1c_vs_match_stat", core_data_o, 32'h1);
    tick();
    set_bus(1'b1, 1'b0, A_STAT, 32'h0, 32'h0);
    #3;
    check("w1c_alone_stat", core_data_o, 32'h0);
    check("w1c_alone_int", 32'(timer_int_o), 32'h0);

    // COUNT write on the match cycle: written value wins, irq still sets.
    set_bus(1'b1, 1'b0, A_CNT, 32'h0, 32'h0);
    repeat (3) tick();
    #3;
    check("cntwr_pre_count", core_data_o, 32'd4);
    set_bus(1'b1, 1'b1, A_CNT, 32'h10, 32'h0);
    tick();
    set_bus(1'b1, 1'b0, A_CNT, 32'h0, 32'h0);
    #3;
    check("cntwr_count", core_data_o, 32'h10);
    check("cntwr_int", 32'(timer_int_o), 32'h1);

    // Disabling freezes count; ie=0 masks the still-pending irq.
    set_bus(1'b1, 1'b1, A_CTRL, 32'h0, 32'h0);
    tick();
    set_bus(1'b1, 1'b0, A_CNT, 32'h0, 32'h0);
    #3;
    check("freeze_count0", core_data_o, 32'h11);
    check("freeze_int_masked", 32'(timer_int_o), 32'h0);
    tick();
    #3;
    check("freeze_count1", core_data_o, 32'h11);
    set_bus(1'b1, 1'b0, A_STAT, 32'h0, 32'h0);
    #1;
    check("freeze_stat", core_data_o, 32'h1);

    // Asynchronous reset in the middle of a running count.
    wr(A_CTRL, 32'd3);
    wr(A_LED, 32'h5A5A);
    tick();
    set_bus(1'b1, 1'b0, A_CNT, 32'h0, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_led", 32'(led_o), 32'h0);
    check("midrst_count", core_data_o, 32'h0);
    check("midrst_int", 32'(timer_int_o), 32'h0);
    set_bus(1'b1, 1'b0, A_CMP, 32'h0, 32'h0);
    #1;
    check("midrst_compare", core_data_o, 32'hFFFF_FFFF);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Switch path.
    set_bus(1'b1, 1'b0, A_SW, 32'h0, 32'h0);
`ifdef SOPC_SW_DEBOUNCE_EN
    switch_i = 12'h0F3;
    repeat (3) tick();
    switch_i = 12'h000;
    repeat (DEB + 6) tick();
    #3;
    check("sw_glitch", core_data_o, 32'h0);
    switch_i = 12'h0F3;
    repeat (4) tick();
    #3;
    check("sw_partial_hold", core_data_o, 32'h0);
    repeat (DEB + 6) tick();
    #3;
    check("sw_held", core_data_o, 32'h0F3);
`else
    switch_i = 12'h0F3;
    #3;
    check("sw_lat0", core_data_o, 32'h0);
    tick();
    #3;
    check("sw_lat1", core_data_o, 32'h0);
    tick();
    #3;
    check("sw_lat2", core_data_o, 32'h0F3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
